i2s_tx: RTL
===========

Name: i2s_tx

Overview:
- Slave-mode I2S transmitter; serializes left/right audio samples onto the codec DAC data line.
- Runs in the audio bclk domain. The codec or clock block drives bclk and lrclk.
- Upstream audio cores (echo, mixers) hand samples over through a valid/ready handshake.
- A one-frame holding buffer decouples the producer from frame timing.

Parameters:
- BITSIZE, 16, sample width in bits; legal range 8..31 (16 and 24 are used in the design).
- SLOT, 32, bclk cycles per channel slot (64 bclk per frame).

Ports:
- bclk  input  1  bit clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  0 forces sdata to 0; samples are still consumed.
- lrclk  input  1  word select: 0 = left slot, 1 = right slot.
- in_left  input  BITSIZE  signed left sample.
- in_right  input  BITSIZE  signed right sample.
- in_valid  input  1  sample pair is valid.
- in_ready  output  1  holding buffer is empty.
- sdata  output  1  serial data, MSB first, registered.
- underrun  output  1  one-cycle pulse when a frame starts with no sample held.
- underrun_count  output  16  saturating count of underruns.

Behaviour:
- Reset, applied at the next posedge while rst=1:
  - sdata=0, underrun=0, underrun_count=0, in_ready=1 (holding buffer empty).
  - Frame registers cleared to 0; state=WAIT_SYNC; bit counter=0; lrclk_q <= lrclk, so no false edge on release.
- Edge detection:
  - lrclk_q is a registered copy of lrclk.
  - fall = lrclk_q & !lrclk; rise = !lrclk_q & lrclk.
  - Slot cycle k=0 is the posedge at which the edge is detected.
- States:
  - WAIT_SYNC: sdata=0 and no buffer transfer. On fall go to LEFT.
  - LEFT: on rise go to RIGHT.
  - RIGHT: on fall go to LEFT.
  - A rise seen in WAIT_SYNC is ignored.
- Frame load, on every fall that enters LEFT:
  - If the holding buffer is full: copy hold_left/hold_right into the frame registers and mark the buffer empty (in_ready=1 from the next cycle).
  - If empty: frame registers <= 0, underrun pulses high for the cycle after k=0, underrun_count increments, saturating at 0xFFFF.
- Serialization:
  - At cycle k=0 of each slot, the shift register loads the frame register for that channel and the bit counter resets to 0.
  - I2S one-bclk delay: the sdata value registered at slot cycle k = sample bit [BITSIZE-k] for 1<=k<=BITSIZE.
  - sdata=0 for k=0 and for k>BITSIZE.
  - The bit counter saturates at SLOT-1; longer slots pad with 0.
- Short slot: an lrclk edge before SLOT cycles restarts the slot immediately. The remaining bits are dropped; no error is flagged.
- Handshake:
  - Accept when in_valid && in_ready: latch both channels and mark the buffer full.
  - in_ready = !full, registered; it deasserts the cycle after acceptance.
  - Acceptance and frame load cannot coincide; the load empties the buffer first.
  - Producer data must be held stable while in_valid && !in_ready (AXI-style).
- enable=0: sdata=0; state machine, buffer drain and underrun accounting continue unchanged. enable is sampled each cycle with no slot alignment.
- Reset mid-slot: outputs follow the reset values next cycle; transmission resumes only after the next lrclk fall.

Decomposition:
- Shared audio package:
  - I2S_SLOT=32 and I2S_FRAME=64.
  - State encoding WAIT_SYNC/LEFT/RIGHT.
  - Counter width localparam $clog2(SLOT).
- Single module.
- Optional sub-module i2s_lr_edge (lrclk register plus fall/rise pulses), reusable by the I2S receiver.

Test Plan:
- Basic frame:
  - Stimulus: reset; lrclk toggles every 32 bclk; BITSIZE=16; push left=16'hA5C3, right=16'h1234 before the first fall.
  - Response: left slot sdata at k=1..16 = 1010010111000011, k=0 and k=17..31 = 0; right slot k=1..16 = 0001001000110100; underrun_count=0.
- Underrun:
  - Stimulus: no push for 3 frames.
  - Response: 3 underrun pulses one cycle after each fall; underrun_count=3; all sdata=0.
  - Follow-up: push 16'h7FFF/16'h8000; the next frame transmits them and underrun_count stays 3.
- Backpressure:
  - Stimulus: hold in_valid=1 with changing data.
  - Response: in_ready=1 is seen once per frame only, in the cycle after the fall load; exactly one pair is accepted per frame; the transmitted pairs match the accepted ones in order.
- Reset mid-slot:
  - Stimulus: assert rst at left slot k=8 for 2 cycles, with lrclk low at release.
  - Response: sdata=0 and in_ready=1 next cycle; no transmission until the following lrclk fall; no underrun is counted while in WAIT_SYNC.
- Short slot and enable:
  - Stimulus: lrclk rises at left k=10.
  - Response: right slot starts at once with MSB at its k=1.
  - Stimulus: enable=0 for one frame with data queued.
  - Response: sdata stays 0 and the buffer is still drained (in_ready pulses).

Source files
------------

// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
//
// Purpose:
//   Shared constants for the I2S audio blocks (transmitter and receiver):
//   slot/frame geometry, the framing state encoding and a small saturating
//   counter helper used for error statistics.
//
// Contents:
//   I2S_SLOT      bclk cycles per channel slot
//   I2S_FRAME     bclk cycles per left+right frame
//   I2S_CNT_W     width of a bit counter that spans one default slot
//   ST_*          framing state encoding (WAIT_SYNC / LEFT / RIGHT)
//   sat_inc16()   16-bit increment that sticks at 0xFFFF
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int I2S_SLOT  = 32;
    localparam int I2S_FRAME = 2 * I2S_SLOT;
    localparam int I2S_CNT_W = $clog2(I2S_SLOT);

    // Framing states. Kept as plain constants so older blocks that compare
    // against raw 2-bit codes keep working.
    localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
    localparam logic [1:0] ST_LEFT      = 2'd1;
    localparam logic [1:0] ST_RIGHT     = 2'd2;

    // Statistics counters must never wrap back to a small value, otherwise a
    // long run of errors would look like a clean link.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/i2s_lr_edge.sv
// ---------------------------------------------------------------------------
// i2s_lr_edge
//
// Purpose:
//   Registers the word-select line (lrclk) in the bclk domain and produces
//   single-cycle fall/rise indications. Shared between the I2S transmitter
//   and receiver so both agree on where a slot begins.
//
// Ports:
//   bclk   in   bit clock, all logic on posedge
//   lrclk  in   word select from the codec / clock block
//   fall   out  high in the cycle lrclk is first seen low after being high
//   rise   out  high in the cycle lrclk is first seen high after being low
// ---------------------------------------------------------------------------
module i2s_lr_edge (
    input  logic bclk,
    input  logic lrclk,
    output logic fall,
    output logic rise
);

    logic lrclk_q;

    // The registered copy always follows lrclk, reset or not. Sampling lrclk
    // during reset means the first cycle after release compares against the
    // real line level, so no phantom edge appears on reset release.
    always_ff @(posedge bclk) begin
        lrclk_q <= lrclk;
    end

    assign fall = lrclk_q & ~lrclk;
    assign rise = ~lrclk_q & lrclk;

endmodule

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx
//
// Purpose:
//   Slave-mode I2S transmitter. Serializes signed left/right samples onto the
//   codec DAC data line, MSB first, one bclk after each word-select edge.
//   A single-pair holding buffer sits between the valid/ready producer and
//   the frame registers, so the producer only has to deliver one pair per
//   frame at any time before the next left slot.
//
// Parameters:
//   BITSIZE  sample width in bits (8..31)
//   SLOT     bclk cycles per channel slot
//
// Ports:
//   bclk            in   bit clock, all logic on posedge
//   rst             in   synchronous active-high reset
//   enable          in   0 forces sdata low; framing and buffering continue
//   lrclk           in   word select, 0 = left slot, 1 = right slot
//   in_left         in   left sample
//   in_right        in   right sample
//   in_valid        in   producer has a sample pair
//   in_ready        out  holding buffer empty, pair will be taken
//   sdata           out  registered serial data
//   underrun        out  one-cycle pulse when a frame starts with no sample
//   underrun_count  out  saturating number of underruns since reset
// ---------------------------------------------------------------------------
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int SLOT    = I2S_SLOT
) (
    input  logic               bclk,
    input  logic               rst,
    input  logic               enable,
    input  logic               lrclk,
    input  logic [BITSIZE-1:0] in_left,
    input  logic [BITSIZE-1:0] in_right,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               sdata,
    output logic               underrun,
    output logic [15:0]        underrun_count
);

    localparam int               CNT_W   = $clog2(SLOT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic               fall;
    logic               rise;
    logic [1:0]         state;
    logic [CNT_W-1:0]   bit_cnt;
    logic               full;
    logic [BITSIZE-1:0] hold_left;
    logic [BITSIZE-1:0] hold_right;
    logic [BITSIZE-1:0] frame_left;
    logic [BITSIZE-1:0] frame_right;
    logic [BITSIZE-1:0] cur_word;
    logic [BITSIZE-1:0] aligned;
    logic               start_left;
    logic               start_right;
    logic               take_hold;
    logic               starve;
    logic               accept;
    logic               slot_bit;

    i2s_lr_edge u_lr_edge (
        .bclk  (bclk),
        .lrclk (lrclk),
        .fall  (fall),
        .rise  (rise)
    );

    // Every fall starts a left slot, even from WAIT_SYNC: that is how the
    // transmitter locks onto the frame. A rise only matters once locked,
    // otherwise we would start mid-frame on a right slot.
    assign start_left  = fall;
    assign start_right = rise && (state != ST_WAIT_SYNC);

    // Frame start either drains the buffer or reports that it had nothing.
    assign take_hold = start_left && full;
    assign starve    = start_left && !full;

    // in_ready comes straight from the buffer flag, so it is a registered
    // signal. A full buffer blocks acceptance, which is what keeps a load
    // and an acceptance from ever landing in the same cycle.
    assign in_ready = !full;
    assign accept   = in_valid && !full;

    // Framing state: locks on the first fall, then alternates on each edge.
    // A short slot simply restarts here because edges always win.
    always_ff @(posedge bclk) begin
        if (rst) begin
            state <= ST_WAIT_SYNC;
        end else if (start_left) begin
            state <= ST_LEFT;
        end else if (start_right) begin
            state <= ST_RIGHT;
        end
    end

    // Holding buffer. The producer is expected to keep its data stable while
    // it waits, so the pair is only captured on the accepting cycle.
    always_ff @(posedge bclk) begin
        if (rst) begin
            full       <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
        end else if (take_hold) begin
            full <= 1'b0;
        end else if (accept) begin
            full       <= 1'b1;
            hold_left  <= in_left;
            hold_right <= in_right;
        end
    end

    // Frame registers hold the pair being transmitted for the whole frame,
    // so the right channel is unaffected by a new pair arriving mid-frame.
    // An empty buffer at frame start sends silence.
    always_ff @(posedge bclk) begin
        if (rst) begin
            frame_left  <= '0;
            frame_right <= '0;
        end else if (take_hold) begin
            frame_left  <= hold_left;
            frame_right <= hold_right;
        end else if (starve) begin
            frame_left  <= '0;
            frame_right <= '0;
        end
    end

    // Bit position within the slot. It counts from the edge cycle and parks
    // at the last slot position so an over-long slot keeps padding zeros
    // instead of wrapping around into the sample again.
    always_ff @(posedge bclk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (start_left || start_right) begin
            bit_cnt <= '0;
        end else if ((state != ST_WAIT_SYNC) && (bit_cnt != CNT_MAX)) begin
            bit_cnt <= bit_cnt + CNT_ONE;
        end
    end

    // The counter reads 0 one cycle after the edge, which gives the I2S
    // one-bclk delay: MSB goes out at slot cycle 1. Shifting the word left
    // by the counter moves the wanted bit to the top; once the counter
    // reaches BITSIZE everything has been shifted out and the line pads 0.
    assign cur_word = (state == ST_RIGHT) ? frame_right : frame_left;
    assign aligned  = cur_word << bit_cnt;
    assign slot_bit = (state != ST_WAIT_SYNC) && !start_left && !start_right
                      && aligned[BITSIZE-1];

    // enable only gates the pin; it is not aligned to slots, so turning it
    // on mid-slot can emit a partial word.
    always_ff @(posedge bclk) begin
        if (rst) begin
            sdata <= 1'b0;
        end else begin
            sdata <= enable & slot_bit;
        end
    end

    // Underrun reporting: a pulse in the cycle after the frame start plus a
    // count that sticks at its maximum.
    always_ff @(posedge bclk) begin
        if (rst) begin
            underrun       <= 1'b0;
            underrun_count <= 16'd0;
        end else begin
            underrun <= starve;
            if (starve) begin
                underrun_count <= sat_inc16(underrun_count);
            end
        end
    end

endmodule
